// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path: FSM state encoding,
// frame geometry and the odd-parity check used when a frame completes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    // Payload bits are the frame minus start, parity and stop.
    localparam int DATA_BITS  = FRAME_BITS - 3;

    // A frame is good when data and parity together hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is presented
// combinationally; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle. The head output reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign count    = count_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver. Synchronises the raw lines, detects filtered
// falling edges of the PS/2 clock, deframes 11-bit frames and queues good
// bytes in a FWFT FIFO. Bad parity, framing errors, timeouts and overflow
// are reported as registered one-cycle pulses.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 5,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               ps2_clock,
    input  logic                               ps2_data,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [7:0]                         rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               parity_err,
    output logic                               frame_err,
    output logic                               overflow
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic                      ps2_clock_meta_reg;
    logic                      ps2_clock_sync_reg;
    logic                      ps2_data_meta_reg;
    logic                      ps2_data_sync_reg;
    logic [2*FILTER_LEN-1:0]   filter_reg;
    logic                      fall;

    ps2_state_t                state_reg;
    ps2_state_t                state_next;
    logic [2:0]                bit_cnt_reg;
    logic [2:0]                bit_cnt_next;
    logic [7:0]                shift_reg;
    logic [7:0]                shift_next;
    logic                      parity_reg;
    logic                      parity_next;
    logic [TO_W-1:0]           timeout_reg;
    logic [TO_W-1:0]           timeout_next;
    logic                      timeout_hit;

    logic                      push_byte;
    logic                      parity_err_next;
    logic                      frame_err_next;
    logic                      overflow_next;
    logic                      parity_err_reg;
    logic                      frame_err_reg;
    logic                      overflow_reg;

    logic                      fifo_full;
    logic                      fifo_empty;

    // Two-flop synchronisers; idle-high reset so release never looks like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2_clock_meta_reg <= 1'b1;
            ps2_clock_sync_reg <= 1'b1;
            ps2_data_meta_reg  <= 1'b1;
            ps2_data_sync_reg  <= 1'b1;
        end else begin
            ps2_clock_meta_reg <= ps2_clock;
            ps2_clock_sync_reg <= ps2_clock_meta_reg;
            ps2_data_meta_reg  <= ps2_data;
            ps2_data_sync_reg  <= ps2_data_meta_reg;
        end
    end

    // Glitch filter history: newest sample enters at bit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filter_reg <= '1;
        end else begin
            filter_reg <= {filter_reg[2*FILTER_LEN-2:0], ps2_clock_sync_reg};
        end
    end

    // A clean fall is FILTER_LEN highs followed by FILTER_LEN lows; the next
    // shift breaks the pattern, so this is a single-cycle strobe.
    assign fall = (&filter_reg[2*FILTER_LEN-1:FILTER_LEN]) && !(|filter_reg[FILTER_LEN-1:0]);

    // An edge arriving in the same cycle as expiry counts as on time.
    assign timeout_hit = (state_reg != IDLE) && !fall && (timeout_reg == TO_LAST);

    // Deframer next-state logic and outcome decode.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        push_byte       = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;
        if (timeout_hit) begin
            state_next     = IDLE;
            bit_cnt_next   = '0;
            frame_err_next = 1'b1;
        end else if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!ps2_data_sync_reg) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {ps2_data_sync_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = ps2_data_sync_reg;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (!ps2_data_sync_reg) begin
                        frame_err_next = 1'b1;
                    end else if (!odd_parity_ok(shift_reg, parity_reg)) begin
                        parity_err_next = 1'b1;
                    end else begin
                        push_byte = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Inactivity counter: cleared on every edge, idle or expiry.
    always_comb begin
        timeout_next = timeout_reg + TO_W'(1);
        if (fall || timeout_hit || state_reg == IDLE) begin
            timeout_next = '0;
        end
    end

    // A full FIFO only drops the byte when no pop frees a slot this cycle.
    assign overflow_next = push_byte && fifo_full && !(rd_ready && !fifo_empty);

    // Deframer state and registered status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            timeout_reg    <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            timeout_reg    <= timeout_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            overflow_reg   <= overflow_next;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_byte),
        .push_data (shift_reg),
        .pop       (rd_ready),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid   = !fifo_empty;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: stimulus tasks drive PS/2 frames and
// queue the expected bytes / status pulses; a monitor on the falling system
// clock edge pops and compares whenever the DUT presents something.
module tb_ps2_rx_fifo;

    localparam int F  = 5;
    localparam int D  = 8;
    localparam int TO = 1000;

    localparam int EV_PERR = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVF  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [3:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_bytes[$];
    int         exp_ev[$];
    bit         rand_ready = 1'b0;
    logic [7:0] mon_exp;
    int         mon_ev;

    always #5 clock = ~clock;

    ps2_rx_fifo #(
        .FILTER_LEN     (F),
        .FIFO_DEPTH     (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Sends the first nbits bits of a frame (11 = complete). Only complete
    // frames update the reference model; partial frames are the caller's job.
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit stop_bit,
                              input int nbits, input int glitch_bit, input int glitch_len,
                              input bit pulse_ready, input bit check_lat);
        logic [10:0] bits;
        logic        par;
        int          hi;
        int          lo;
        par  = ~(^data) ^ bad_par;
        bits = {stop_bit, par, data, 1'b0};
        if (nbits == 11) begin
            if (!stop_bit)                                    exp_ev.push_back(EV_FERR);
            else if (bad_par)                                 exp_ev.push_back(EV_PERR);
            else if (exp_bytes.size() >= D && !pulse_ready)   exp_ev.push_back(EV_OVF);
            else                                              exp_bytes.push_back(data);
        end
        for (int i = 0; i < nbits; i++) begin
            hi = $urandom_range(8, 14);
            lo = $urandom_range(9, 14);
            ps2_data = bits[i];
            if (i == glitch_bit && glitch_len > 0) begin
                tick(2);
                ps2_clock = 1'b0;
                tick(glitch_len);
                ps2_clock = 1'b1;
            end
            tick(hi);
            ps2_clock = 1'b0;
            if (i == 10 && (pulse_ready || check_lat)) begin
                // Filtered edge is live now; the push lands on the next edge.
                tick(F + 2);
                if (check_lat) chk("count_before_push", fifo_count, exp_bytes.size() - 1);
                if (pulse_ready) rd_ready = 1'b1;
                tick(1);
                if (pulse_ready) rd_ready = 1'b0;
                if (check_lat) begin
                    chk("valid_after_push", rd_valid, 1);
                    chk("count_after_push", fifo_count, exp_bytes.size());
                end
                tick(lo - F - 3);
            end else begin
                tick(lo);
            end
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
        tick(10);
        $display("frame 0x%02h bad_par=%0d stop=%0d bits=%0d glitch=%0d/%0d", data, bad_par, stop_bit, nbits, glitch_bit, glitch_len);
    endtask

    // Short low pulse on the clock while data is low: must not start a frame.
    task automatic idle_glitch(input int len);
        ps2_data = 1'b0;
        tick(3);
        ps2_clock = 1'b0;
        tick(len);
        ps2_clock = 1'b1;
        tick(3);
        ps2_data = 1'b1;
        tick(12);
        $display("idle glitch len=%0d", len);
    endtask

    task automatic ev_check(input logic pulse, input int kind, input string nm);
        if (pulse) begin
            if (exp_ev.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_%s: got pulse required none at %0t", nm, $time);
            end else begin
                mon_ev = exp_ev.pop_front();
                chk(nm, kind, mon_ev);
            end
        end
    endtask

    // Monitor: compares consumed bytes and status pulses against the queues.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (rd_valid && rd_ready) begin
                    if (exp_bytes.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got 0x%02h required none at %0t", rd_data, $time);
                    end else begin
                        mon_exp = exp_bytes.pop_front();
                        chk("rd_data", rd_data, mon_exp);
                    end
                end
                ev_check(parity_err, EV_PERR, "parity_err");
                ev_check(frame_err,  EV_FERR, "frame_err");
                ev_check(overflow,   EV_OVF,  "overflow");
            end
        end
    end

    initial begin
        int gb;
        int gl;
        #2;
        reset = 1'b1;
        tick(4);
        chk("reset_rd_valid",   rd_valid, 0);
        chk("reset_rd_data",    rd_data, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_parity_err", parity_err, 0);
        chk("reset_frame_err",  frame_err, 0);
        chk("reset_overflow",   overflow, 0);
        reset = 1'b0;
        tick(20);

        // Basic frames and error outcomes.
        rd_ready = 1'b1;
        send_frame(8'h1C, 0, 1, 11, -1, 0, 0, 0);
        send_frame(8'h1C, 1, 1, 11, -1, 0, 0, 0);
        chk("count_after_parity_err", fifo_count, 0);
        send_frame(8'h1C, 0, 0, 11, -1, 0, 0, 0);
        chk("count_after_frame_err", fifo_count, 0);

        // Glitches below the filter length, idle and mid-frame.
        idle_glitch(1);
        idle_glitch(F - 1);
        send_frame(8'hF0, 0, 1, 11, 3, 1, 0, 0);
        send_frame(8'hF0, 0, 1, 11, 6, F - 1, 0, 0);

        // Abandoned frame times out, then a clean frame follows.
        exp_ev.push_back(EV_FERR);
        send_frame(8'h33, 0, 1, 4, -1, 0, 0, 0);
        tick(TO + 20);
        send_frame(8'h5A, 0, 1, 11, -1, 0, 0, 0);

        // Fill past capacity with no consumer.
        rd_ready = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            send_frame(8'(v), 0, 1, 11, -1, 0, 0, (v == 1));
        end
        chk("count_full", fifo_count, D);
        chk("valid_full", rd_valid, 1);
        // Push while full with a simultaneous pop: no overflow, count held.
        send_frame(8'h0A, 0, 1, 11, -1, 0, 1, 0);
        chk("count_full_push_pop", fifo_count, D);
        rd_ready = 1'b1;
        tick(20);
        chk("drained_valid", rd_valid, 0);
        chk("drained_count", fifo_count, 0);

        // Randomised traffic with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            gl = $urandom_range(0, 2);
            gl = (gl == 0) ? 0 : ((gl == 1) ? 1 : F - 1);
            gb = $urandom_range(0, 10);
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) != 0), 11, gb, gl, 0, 0);
        end
        rand_ready = 1'b0;
        rd_ready = 1'b1;
        tick(30);

        // Reset in the middle of a frame with bytes still queued.
        rd_ready = 1'b0;
        send_frame(8'h11, 0, 1, 11, -1, 0, 0, 0);
        send_frame(8'h22, 0, 1, 11, -1, 0, 0, 0);
        chk("count_before_reset", fifo_count, 2);
        send_frame(8'h44, 0, 1, 5, -1, 0, 0, 0);
        reset = 1'b1;
        #1;
        exp_bytes.delete();
        exp_ev.delete();
        chk("midreset_rd_valid",   rd_valid, 0);
        chk("midreset_rd_data",    rd_data, 0);
        chk("midreset_fifo_count", fifo_count, 0);
        chk("midreset_parity_err", parity_err, 0);
        chk("midreset_frame_err",  frame_err, 0);
        chk("midreset_overflow",   overflow, 0);
        tick(3);
        reset = 1'b0;
        tick(10);
        rd_ready = 1'b1;
        send_frame(8'hA5, 0, 1, 11, -1, 0, 0, 0);
        tick(30);

        chk("bytes_outstanding",  exp_bytes.size(), 0);
        chk("events_outstanding", exp_ev.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with buffered output. Samples the PS/2 clock and data lines, applies a configurable glitch filter to the clock, and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Valid bytes go into an internal FIFO drained by a valid/ready consumer such as the keyboard scancode decoder. Parity, framing, timeout and overflow conditions are reported rather than silently dropped.

## Interface

- FILTER_LEN, 5: consecutive stable samples required on each side of a PS/2 clock falling edge (≥2).
- FIFO_DEPTH, 8: byte entries in the output FIFO (power of two, ≥2).
- TIMEOUT_CYCLES, 50000: clocks without a PS/2 clock edge before an in-progress frame is aborted.

Ports:

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ps2_clock  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  8  head-of-FIFO byte (first-word fall-through).
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- parity_err  out  1  one-cycle pulse: frame with bad parity discarded.
- frame_err  out  1  one-cycle pulse: stop bit 0, or timeout abort.
- overflow  out  1  one-cycle pulse: good byte dropped, FIFO full.

## Operation

- ps2_clock and ps2_data pass through 2-FF synchronisers.
- Edge detect uses a 2×FILTER_LEN shift register of synced ps2_clock. `fall` is asserted when the older FILTER_LEN samples are all 1 and the newer FILTER_LEN samples are all 0. `fall` is a single-cycle strobe.
- FSM state changes only on `fall` or on timeout:
  - IDLE: data=0 → DATA with bit_cnt=0. data=1 → stay in IDLE (spurious edge ignored).
  - DATA: shift data into shift_reg LSB-first and increment bit_cnt. After the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: evaluate and → IDLE. Good frame means stop=1 and ^{data,parity}=1.
- Outcomes in STOP, evaluated in priority order:
  - stop=0 → frame_err.
  - else bad parity → parity_err.
  - else push the byte.
- Timeout: a counter clears on every `fall` and runs while the state is not IDLE. On reaching TIMEOUT_CYCLES−1: → IDLE, bit_cnt cleared, frame_err pulse, no push.
- FIFO behaviour:
  - Pop when rd_valid && rd_ready.
  - Push when full and no simultaneous pop → byte dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle while full → both performed, count unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: FSM goes to IDLE and the FIFO is emptied. The remainder of the line activity is ignored until the next start bit.
- Reset values: rd_valid=0, rd_data=0, fifo_count=0, parity_err=0, frame_err=0, overflow=0. Synchroniser and filter registers reset to all 1s (idle-high line), so reset release gives no false `fall`.

## Timing

- `fall` asserts 2+FILTER_LEN clocks after the physical PS/2 clock falls.
- A good byte appears as rd_valid=1 and the updated fifo_count on the clock edge after the stop-bit `fall` cycle.
- Error and overflow pulses are registered and align with that same edge.
- rd_data and rd_valid are combinational from FIFO state; rd_data changes the cycle after a pop.
- Minimum sustainable PS/2 clock half-period: FILTER_LEN+1 system clocks.

## Structure

- Package ps2_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - a frame-width constant of 11;
  - the odd-parity check function.
- The FIFO is a separate sub-module, sync_fifo (parameters WIDTH, DEPTH; first-word fall-through; full/empty/count; push/pop). The deframer instantiates it.

## Test plan

- Frame for 0x1C (parity 0, stop 1), rd_ready=1 → one rd_valid cycle with rd_data=0x1C; no error pulses.
- 0x1C sent with parity 1 → parity_err pulse once; fifo_count stays 0. Repeat with stop=0 → frame_err only.
- 1-cycle and FILTER_LEN−1-cycle low glitches on ps2_clock while idle and mid-frame → no `fall`; the next frame 0xF0 is received correctly.
- Start bit plus 3 bits, then silence for TIMEOUT_CYCLES → frame_err pulse and state IDLE; a following 0x5A frame is received intact.
- rd_ready=0, then send FIFO_DEPTH+1 frames 0x01..0x09 → fifo_count=8 and one overflow pulse. Then drain: bytes 0x01..0x08 in order, and rd_valid drops after the 8th.
- FIFO full with rd_ready=1 held exactly on the stop-bit push cycle → no overflow; fifo_count stays 8. Assert reset mid-frame → all outputs return to their reset values at once.
